// File: rtl/tohost_pkg.sv
// Shared types and constants for the tohost completion monitor.
// No logic; imported by the monitor and its bench.
package tohost_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [11:0] TOHOST_CSR = 12'h51E;
  localparam int          FAIL_ID_W  = 31;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over en, one-cycle update latency.
// No backpressure: en is sampled every cycle, async active-low reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/tohost_monitor.sv
// Watches tohost CSR writes for pass/fail, captures test id and run length, runs a watchdog.
// Outputs registered, one-edge latency; no backpressure, writes in terminal states are dropped.
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter logic [11:0] TOHOST_ADDR    = TOHOST_CSR,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          CYCLE_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csr_we,
  input  logic [11:0]          csr_addr,
  input  logic [31:0]          csr_wdata,
  input  logic                 clear,
  output logic                 running,
  output logic                 passed,
  output logic                 failed,
  output logic                 timed_out,
  output logic                 done_pulse,
  output logic [FAIL_ID_W-1:0] fail_id,
  output logic [CYCLE_W-1:0]   cycle_count
);

  localparam logic [CYCLE_W-1:0] WD_LAST = CYCLE_W'(TIMEOUT_CYCLES - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic [FAIL_ID_W-1:0]   r_fail_id;
  logic                   w_capture;
  logic                   w_cnt_en;
  logic                   w_term;
  logic                   w_wd_hit;
  logic [CYCLE_W-1:0]     w_cnt;

  assign w_term   = csr_we && (csr_addr == TOHOST_ADDR) && csr_wdata[0];
  assign w_wd_hit = (TIMEOUT_CYCLES != 0) && (w_cnt == WD_LAST);

  // The counter only advances on plain RUN cycles, so it freezes on the terminating edge.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    w_cnt_en    = 1'b0;
    if (clear) begin
      w_state_nxt = ST_RUN;
    end else if (r_state == ST_RUN) begin
      if (w_term) begin
        w_state_nxt = (csr_wdata[31:1] == '0) ? ST_PASS : ST_FAIL;
        w_done_nxt  = 1'b1;
        w_capture   = 1'b1;
      end else if (w_wd_hit) begin
        w_state_nxt = ST_TIMEOUT;
        w_done_nxt  = 1'b1;
      end else begin
        w_cnt_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_done    <= 1'b0;
      r_fail_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (clear) begin
        r_fail_id <= '0;
      end else if (w_capture) begin
        r_fail_id <= csr_wdata[31:1];
      end
    end
  end

  sat_counter #(
    .W (CYCLE_W)
  ) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .en  (w_cnt_en),
    .q   (w_cnt)
  );

  assign running     = (r_state == ST_RUN);
  assign passed      = (r_state == ST_PASS);
  assign failed      = (r_state == ST_FAIL);
  assign timed_out   = (r_state == ST_TIMEOUT);
  assign done_pulse  = r_done;
  assign fail_id     = r_fail_id;
  assign cycle_count = w_cnt;

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: default instance against a behavioural model plus literal pins,
// and a small no-watchdog instance checked for counter saturation.
module tb_tohost_monitor;

  localparam int T_A = 1000;

  logic        clk;
  logic        rst;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        clear;

  logic        a_running, a_passed, a_failed, a_timed_out, a_done;
  logic [30:0] a_fail_id;
  logic [31:0] a_count;

  logic        b_we;
  logic [11:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_clear;
  logic        b_running, b_passed, b_failed, b_timed_out, b_done;
  logic [30:0] b_fail_id;
  logic [3:0]  b_count;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  tohost_monitor #(
    .TOHOST_ADDR    (12'h51E),
    .TIMEOUT_CYCLES (T_A),
    .CYCLE_W        (32)
  ) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .clear       (clear),
    .running     (a_running),
    .passed      (a_passed),
    .failed      (a_failed),
    .timed_out   (a_timed_out),
    .done_pulse  (a_done),
    .fail_id     (a_fail_id),
    .cycle_count (a_count)
  );

  tohost_monitor #(
    .TOHOST_ADDR    (12'h51E),
    .TIMEOUT_CYCLES (0),
    .CYCLE_W        (4)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .csr_we      (b_we),
    .csr_addr    (b_addr),
    .csr_wdata   (b_wdata),
    .clear       (b_clear),
    .running     (b_running),
    .passed      (b_passed),
    .failed      (b_failed),
    .timed_out   (b_timed_out),
    .done_pulse  (b_done),
    .fail_id     (b_fail_id),
    .cycle_count (b_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: 0 run, 1 pass, 2 fail, 3 timeout.
  int      m_st;
  longint  m_cnt;
  logic [30:0] m_fid;
  logic    m_done;
  int      b_cyc;
  logic    m_term;

  assign m_term = csr_we && (csr_addr == 12'h51E) && csr_wdata[0];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st   <= 0;
      m_cnt  <= 0;
      m_fid  <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (clear) begin
        m_st  <= 0;
        m_cnt <= 0;
        m_fid <= '0;
      end else if (m_st == 0) begin
        if (m_term) begin
          m_st   <= (csr_wdata[31:1] == 31'd0) ? 1 : 2;
          m_fid  <= csr_wdata[31:1];
          m_done <= 1'b1;
        end else if (m_cnt == T_A - 1) begin
          m_st   <= 3;
          m_done <= 1'b1;
        end else begin
          m_cnt <= (m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
        end
      end
    end
  end

  // Instance B never terminates: its count is simply cycles since reset, capped at 15.
  always @(posedge clk or negedge rst) begin
    if (!rst) b_cyc <= 0;
    else if (b_cyc < 15) b_cyc <= b_cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_flags", {27'd0, a_running, a_passed, a_failed, a_timed_out, a_done},
          {27'd0, m_st == 0, m_st == 1, m_st == 2, m_st == 3, m_done});
      chk("a_fail_id", {1'b0, a_fail_id}, {1'b0, m_fid});
      chk("a_count", a_count, m_cnt[31:0]);
      chk("b_flags", {27'd0, b_running, b_passed, b_failed, b_timed_out, b_done}, 32'h10);
      chk("b_count", {28'd0, b_count}, 32'(b_cyc));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    cyc(1);
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    csr_we = 1'b0; csr_addr = '0; csr_wdata = '0; clear = 1'b0;
    b_we = 1'b0; b_addr = '0; b_wdata = '0; b_clear = 1'b0;
    #1 rst = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    chk("rst_flags", {27'd0, a_running, a_passed, a_failed, a_timed_out, a_done}, 32'h10);
    chk("rst_count", a_count, 32'd0);
    chk("rst_fail_id", {1'b0, a_fail_id}, 32'd0);
    rst = 1'b1;

    // Pass at cycle 50.
    cyc(50);
    chk("pre_pass_count", a_count, 32'd50);
    wr(12'h51E, 32'h1);
    chk("pass_flags", {27'd0, a_running, a_passed, a_failed, a_timed_out, a_done}, 32'h09);
    chk("pass_count", a_count, 32'd50);
    chk("pass_fail_id", {1'b0, a_fail_id}, 32'd0);
    cyc(1);
    chk("pass_done_drop", {31'd0, a_done}, 32'd0);
    chk("pass_sticky", {31'd0, a_passed}, 32'd1);
    chk("sat_b_count", {28'd0, b_count}, 32'd15);
    chk("sat_b_running", {31'd0, b_running}, 32'd1);

    // Clear, then fail with test 3, then a later pass write is ignored.
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk("clear_running", {31'd0, a_running}, 32'd1);
    chk("clear_count", a_count, 32'd0);
    cyc(5);
    wr(12'h51E, 32'h7);
    chk("fail_flags", {27'd0, a_running, a_passed, a_failed, a_timed_out, a_done}, 32'h05);
    chk("fail_id3", {1'b0, a_fail_id}, 32'd3);
    chk("fail_count", a_count, 32'd5);
    wr(12'h51E, 32'h1);
    cyc(1);
    chk("fail_hold_flags", {27'd0, a_running, a_passed, a_failed, a_timed_out, a_done}, 32'h04);
    chk("fail_hold_id", {1'b0, a_fail_id}, 32'd3);

    // Clear together with a terminating write: write dropped.
    clear = 1'b1; csr_we = 1'b1; csr_addr = 12'h51E; csr_wdata = 32'h7;
    cyc(1);
    clear = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    chk("clrwr_flags", {27'd0, a_running, a_passed, a_failed, a_timed_out, a_done}, 32'h10);
    chk("clrwr_count", a_count, 32'd0);
    chk("clrwr_fail_id", {1'b0, a_fail_id}, 32'd0);

    // Non-terminating writes, then watchdog expiry.
    wr(12'h51E, 32'h0);
    wr(12'h51E, 32'h2);
    wr(12'h300, 32'h1);
    chk("ignored_flags", {27'd0, a_running, a_passed, a_failed, a_timed_out, a_done}, 32'h10);
    chk("ignored_count", a_count, 32'd3);
    cyc(996);
    chk("wd_last_count", a_count, 32'd999);
    chk("wd_last_running", {31'd0, a_running}, 32'd1);
    cyc(1);
    chk("timeout_flags", {27'd0, a_running, a_passed, a_failed, a_timed_out, a_done}, 32'h03);
    chk("timeout_count", a_count, 32'd999);

    // Terminating write on the watchdog cycle wins.
    clear = 1'b1; cyc(1); clear = 1'b0;
    cyc(999);
    wr(12'h51E, 32'h1);
    chk("wdwr_flags", {27'd0, a_running, a_passed, a_failed, a_timed_out, a_done}, 32'h09);
    chk("wdwr_count", a_count, 32'd999);

    // Asynchronous reset between edges at count 20.
    clear = 1'b1; cyc(1); clear = 1'b0;
    cyc(20);
    chk("pre_arst_count", a_count, 32'd20);
    #1 rst = 1'b0;
    #1;
    chk("arst_flags", {27'd0, a_running, a_passed, a_failed, a_timed_out, a_done}, 32'h10);
    chk("arst_count", a_count, 32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("post_arst_count", a_count, 32'd1);
    cyc(4);
    chk("post_arst_count5", a_count, 32'd5);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tohost_monitor.md
# tohost_monitor

Synthesizable completion monitor that sits directly downstream of the CPU's CSR write port and consumes the tohost (`0x51E`) writes that ISA test programs use to report results. It decodes pass/fail, captures the failing test number and the elapsed cycle count, and runs a timeout watchdog. Simulation benches and on-board status logic (LEDs, UART report) read its outputs instead of probing CSR internals hierarchically.

## Interface
Parameters:
- `TOHOST_ADDR`, 12'h51E: CSR address that is monitored.
- `TIMEOUT_CYCLES`, 1000: cycles in RUN before declaring timeout; 0 disables the watchdog.
- `CYCLE_W`, 32: width of the cycle counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `csr_we`  in  1  CPU CSR write strobe for the current cycle.
- `csr_addr`  in  12  CSR write address.
- `csr_wdata`  in  32  CSR write data.
- `clear`  in  1  synchronous re-arm pulse: return to RUN and zero the counter.
- `running`  out  1  high in RUN.
- `passed`  out  1  sticky; high in PASS.
- `failed`  out  1  sticky; high in FAIL.
- `timed_out`  out  1  sticky; high in TIMEOUT.
- `done_pulse`  out  1  one-cycle pulse on the cycle the block enters any terminal state.
- `fail_id`  out  31  `csr_wdata[31:1]` captured by the terminating write.
- `cycle_count`  out  CYCLE_W  cycles spent in RUN; frozen in terminal states.

## Operation
- States: RUN, PASS, FAIL, TIMEOUT. Reset enters RUN with all outputs 0 except `running`=1. `cycle_count`=0, `fail_id`=0, `done_pulse`=0.
- Terminating write: `csr_we`=1, `csr_addr`==`TOHOST_ADDR`, `csr_wdata[0]`=1. Writes with bit0=0, or to other addresses, are ignored.
- RUN: `cycle_count` increments each cycle and saturates at all-ones with no wrap.
  - Terminating write with `csr_wdata[31:1]`==0 goes to PASS.
  - Terminating write with nonzero `csr_wdata[31:1]` goes to FAIL.
  - Either terminating write captures `fail_id` = `csr_wdata[31:1]`. On PASS this is 0.
- Watchdog: in RUN with `TIMEOUT_CYCLES`≠0, the block goes to TIMEOUT when `cycle_count` == `TIMEOUT_CYCLES`-1 and no terminating write is present that cycle.
- Terminal states: hold until `clear`. All CSR writes are ignored and `cycle_count` does not change.
- `clear` in any state: next state RUN, `cycle_count`=0, `fail_id`=0, sticky flags cleared.
- Priority within one cycle:
  - `clear` beats a terminating write, which beats the watchdog.
  - A write together with `clear` is dropped.
  - A terminating write on the watchdog cycle yields PASS or FAIL, not TIMEOUT.
- Reset asserted mid-run returns to the reset state immediately, without waiting for a clock edge.

## Timing
- All outputs are registered with no combinational path from inputs.
- Terminating write sampled at edge N: at edge N the state changes and `done_pulse` rises. `done_pulse` is visible during cycle N+1 and drops at edge N+1.
- `cycle_count` in the terminal state is the value it held during the cycle the write was presented. The write cycle itself is not counted.
- After reset release, the first edge with `rst`=1 moves `cycle_count` from 0 to 1.
- Timeout with `TIMEOUT_CYCLES`=T: TIMEOUT is entered at the edge where the count would reach T. `cycle_count` freezes at T-1.
- `clear` takes effect at the next edge. `running` is 1 in the following cycle.

## Structure
- Package `tohost_pkg` holds:
  - the state enum (RUN, PASS, FAIL, TIMEOUT);
  - `TOHOST_CSR` = 12'h51E;
  - the `fail_id` width constant.
- Sub-module `sat_counter`: parameterized width, with synchronous `clr` and `en` inputs, saturates at max, async active-low reset. Used for `cycle_count`.
- The FSM and capture registers live in `tohost_monitor`.

## Test plan
- Reset, then terminating write of 32'h1 at cycle 50 → `passed`=1, `fail_id`=0, `cycle_count`=50, `done_pulse` high for exactly one cycle.
- Write 32'h7 (test 3) → `failed`=1, `fail_id`=3. A later write of 32'h1 leaves all outputs unchanged.
- Writes of 32'h0 and 32'h2 to `0x51E`, and 32'h1 to `0x300` → no state change. With T=1000 the block reaches `timed_out`=1 with `cycle_count`=999.
- Terminating write 32'h1 on the watchdog cycle (`cycle_count`=999) → PASS, not TIMEOUT. `clear` together with a write in FAIL → RUN with `cycle_count`=0 and the write dropped.
- `TIMEOUT_CYCLES`=0, `CYCLE_W`=4, run 40 cycles → `cycle_count` saturates at 15 and `running` stays 1.
- Assert `rst`=0 asynchronously between edges during RUN at count 20 → outputs return to reset values immediately. After release, counting restarts from 0.
